cfg_tlp_handler: RTL and testbench

//  Upstream request/completion engine for the config register file. Accepts one

---
 rtl/cfg_tlp_handler.sv | 185 ++++++++++++++++++
 tb/tb_cfg_tlp_handler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_tlp_handler.sv
// ---------------------------------------------------------------------------
// cfg_tlp_handler
//   Upstream request/completion engine for the config register file.
//   Takes one decoded Type-0 config request (3DW header + 1 DW payload),
//   fires a single-cycle read or write strobe into config space, captures the
//   read data and returns a Cpl/CplD toward the TX completion arbiter.
//   Only one request is in flight at a time: IDLE -> ACCESS -> CPL -> IDLE.
//
//   Header packing (rx_hdr and tx_hdr): DW0 = [31:0], DW1 = [63:32],
//   DW2 = [95:64].
//
// Optional feature macro: CFG_UR_CNT_EN
//   When defined, adds the ur_count output, a saturating count of UR
//   completions handed off to TX.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   rx_valid/ready request handshake (ready only in IDLE)
//   rx_hdr         request header; rx_data write payload
//   cfg_rd_en      read strobe;  cfg_wr_en write strobe (1 cycle each)
//   cfg_addr_dw    DW offset; cfg_wdata write data; cfg_be byte enables
//   cfg_rdata      combinational read data, valid while cfg_rd_en
//   tx_valid/ready completion handshake; tx_hdr/tx_data/tx_has_data payload
//   ur_count       (CFG_UR_CNT_EN) unsupported-request completion count
// ---------------------------------------------------------------------------
module cfg_tlp_handler #(
  parameter int CFG_DWORDS = 64,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [95:0]       rx_hdr,
  input  logic [31:0]       rx_data,
  output logic              cfg_rd_en,
  output logic              cfg_wr_en,
  output logic [ADDR_W-1:0] cfg_addr_dw,
  output logic [31:0]       cfg_wdata,
  output logic [3:0]        cfg_be,
  input  logic [31:0]       cfg_rdata,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [95:0]       tx_hdr,
  output logic [31:0]       tx_data,
  output logic              tx_has_data
`ifdef CFG_UR_CNT_EN
  ,
  output logic [15:0]       ur_count
`endif
);

  localparam logic [7:0] FT_CFGRD0 = 8'h04;
  localparam logic [7:0] FT_CFGWR0 = 8'h44;
  localparam logic [7:0] FT_CPL    = 8'h0A;
  localparam logic [7:0] FT_CPLD   = 8'h4A;
  localparam logic [2:0] ST_SC     = 3'b000;
  localparam logic [2:0] ST_UR     = 3'b001;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CPL} state_t;

  // Latched request, already classified at accept time so ACCESS and CPL
  // only look at flags.
  typedef struct packed {
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [15:0] bdf;
    logic [9:0]  off;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rd;      // supported CfgRd0, length 1
    logic        wr;      // supported CfgWr0, length 1
    logic        ur;      // anything else
    logic        in_rng;  // offset inside implemented space
  } req_t;

  state_t      state, state_nxt;
  req_t        rx_req, req_q;
  logic [31:0] rdata_q;

  // ---- request decode ----
  logic [7:0] rx_ft;
  logic [9:0] rx_len;
  logic [9:0] rx_off;
  logic       rx_len1;

  assign rx_ft   = rx_hdr[31:24];
  assign rx_len  = rx_hdr[9:0];
  assign rx_off  = rx_hdr[75:66];
  assign rx_len1 = (rx_len == 10'd1);

  // Header bits this block has no use for.
  logic unused_hdr;
  assign unused_hdr = ^{rx_hdr[23:10], rx_hdr[39:36], rx_hdr[79:76], rx_hdr[65:64]};

  always_comb begin
    rx_req        = '0;
    rx_req.req_id = rx_hdr[63:48];
    rx_req.tag    = rx_hdr[47:40];
    rx_req.be     = rx_hdr[35:32];
    rx_req.bdf    = rx_hdr[95:80];
    rx_req.off    = rx_off;
    rx_req.wdata  = rx_data;
    rx_req.rd     = (rx_ft == FT_CFGRD0) && rx_len1;
    rx_req.wr     = (rx_ft == FT_CFGWR0) && rx_len1;
    rx_req.ur     = !(rx_req.rd || rx_req.wr);
    rx_req.in_rng = ({22'd0, rx_off} < CFG_DWORDS);
  end

  // ---- state / datapath registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (rx_valid && rx_ready)
        req_q <= rx_req;
      // Out-of-range and non-strobed reads complete with zero data.
      if (state == S_ACCESS)
        rdata_q <= cfg_rd_en ? cfg_rdata : 32'd0;
    end
  end

  // ---- next state / control ----
  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    cfg_rd_en = 1'b0;
    cfg_wr_en = 1'b0;
    tx_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        // Reads with BE==0 still strobe; writes with BE==0 are dropped.
        cfg_rd_en = req_q.rd && req_q.in_rng;
        cfg_wr_en = req_q.wr && req_q.in_rng && (req_q.be != 4'd0);
        state_nxt = S_CPL;
      end
      S_CPL: begin
        tx_valid = 1'b1;
        if (tx_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- config-space side: only driven during ACCESS ----
  logic in_access;
  assign in_access   = (state == S_ACCESS);
  assign cfg_addr_dw = in_access ? ADDR_W'(req_q.off) : '0;
  assign cfg_wdata   = in_access ? req_q.wdata : 32'd0;
  assign cfg_be      = in_access ? req_q.be : 4'd0;

  // ---- completion ----
  // Every supported read (including out-of-range) returns CplD; writes and
  // URs return a data-less Cpl.
  logic        has_d;
  logic [2:0]  cpl_st;
  logic [31:0] cpl_dw0, cpl_dw1, cpl_dw2;

  assign has_d   = req_q.rd;
  assign cpl_st  = req_q.ur ? ST_UR : ST_SC;
  assign cpl_dw0 = {(has_d ? FT_CPLD : FT_CPL), 14'd0, (has_d ? 10'd1 : 10'd0)};
  assign cpl_dw1 = {req_q.bdf, cpl_st, 1'b0, 12'd4};
  assign cpl_dw2 = {req_q.req_id, req_q.tag, 1'b0, 7'd0};

  assign tx_hdr      = tx_valid ? {cpl_dw2, cpl_dw1, cpl_dw0} : 96'd0;
  assign tx_data     = (tx_valid && has_d) ? rdata_q : 32'd0;
  assign tx_has_data = tx_valid && has_d;

`ifdef CFG_UR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ur_count <= 16'd0;
    else if (tx_valid && tx_ready && req_q.ur && (ur_count != 16'hFFFF))
      ur_count <= ur_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_cfg_tlp_handler.sv
// Self-checking bench for cfg_tlp_handler: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_cfg_tlp_handler;
  localparam int CFG_DWORDS = 64;
  localparam int ADDR_W     = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_valid, rx_ready;
  logic [95:0]       rx_hdr;
  logic [31:0]       rx_data;
  logic              cfg_rd_en, cfg_wr_en;
  logic [ADDR_W-1:0] cfg_addr_dw;
  logic [31:0]       cfg_wdata;
  logic [3:0]        cfg_be;
  logic [31:0]       cfg_rdata;
  logic              tx_valid, tx_ready;
  logic [95:0]       tx_hdr;
  logic [31:0]       tx_data;
  logic              tx_has_data;
`ifdef CFG_UR_CNT_EN
  logic [15:0]       ur_count;
`endif

  always #5 clk = ~clk;

  cfg_tlp_handler #(.CFG_DWORDS(CFG_DWORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_hdr(rx_hdr), .rx_data(rx_data),
    .cfg_rd_en(cfg_rd_en), .cfg_wr_en(cfg_wr_en), .cfg_addr_dw(cfg_addr_dw),
    .cfg_wdata(cfg_wdata), .cfg_be(cfg_be), .cfg_rdata(cfg_rdata),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_hdr(tx_hdr), .tx_data(tx_data),
    .tx_has_data(tx_has_data)
`ifdef CFG_UR_CNT_EN
    , .ur_count(ur_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---- config space responder (what the DUT actually writes/reads) ----
  logic [31:0] mem [0:1023];
  assign cfg_rdata = cfg_rd_en ? mem[cfg_addr_dw] : 32'hDEADBEEF;
  always @(posedge clk) begin
    if (cfg_wr_en)
      for (int b = 0; b < 4; b++)
        if (cfg_be[b]) mem[cfg_addr_dw][8*b +: 8] <= cfg_wdata[8*b +: 8];
  end

  // ---- reference model ----
  logic [31:0] shadow [0:1023];
  logic        m_busy = 1'b0;
  int          m_age = 0;         // cycles since accept: 1 = strobe cycle, 2 = completion
  int          acc_cnt = 0;
  int          m_urcnt = 0;
  logic [7:0]  m_ft, m_tag;
  logic [9:0]  m_len, m_off;
  logic [15:0] m_rid, m_bdf;
  logic [3:0]  m_be;
  logic [31:0] m_wd, m_data;
  logic [95:0] m_hdr;
  logic        m_hasd;

  function automatic bit exp_rd();  return (m_ft == 8'h04) && (m_len == 10'd1); endfunction
  function automatic bit exp_wr();  return (m_ft == 8'h44) && (m_len == 10'd1); endfunction
  function automatic bit exp_ur();  return !(exp_rd() || exp_wr()); endfunction
  function automatic bit exp_inr(); return int'(m_off) < CFG_DWORDS; endfunction

  function automatic logic [95:0] mk_req(input logic [7:0] ft, input logic [9:0] len,
      input logic [15:0] rid, input logic [7:0] tag, input logic [3:0] be,
      input logic [15:0] bdf, input logic [9:0] off);
    logic [95:0] h;
    h = '0;
    h[31:24] = ft;  h[9:0] = len;
    h[63:48] = rid; h[47:40] = tag; h[35:32] = be;
    h[95:80] = bdf; h[75:66] = off;
    return h;
  endfunction

  function automatic logic [95:0] cpl_hdr(input bit rd, input bit ur, input logic [15:0] bdf,
      input logic [15:0] rid, input logic [7:0] tag);
    logic [95:0] h;
    h = '0;
    h[31:24] = rd ? 8'h4A : 8'h0A;
    h[9:0]   = rd ? 10'd1 : 10'd0;
    h[63:48] = bdf;
    h[47:45] = ur ? 3'b001 : 3'b000;
    h[43:32] = 12'd4;
    h[95:80] = rid;
    h[79:72] = tag;
    return h;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_age   <= 0;
      m_urcnt <= 0;
    end else if (!m_busy) begin
      if (rx_valid) begin
        m_ft  <= rx_hdr[31:24]; m_len <= rx_hdr[9:0];
        m_rid <= rx_hdr[63:48]; m_tag <= rx_hdr[47:40]; m_be <= rx_hdr[35:32];
        m_bdf <= rx_hdr[95:80]; m_off <= rx_hdr[75:66];
        m_wd  <= rx_data;
        m_busy <= 1'b1;
        m_age  <= 1;
        acc_cnt <= acc_cnt + 1;
      end
    end else if (m_age == 1) begin
      m_age <= 2;
      if (exp_wr() && exp_inr())
        for (int b = 0; b < 4; b++)
          if (m_be[b]) shadow[m_off][8*b +: 8] <= m_wd[8*b +: 8];
      m_hasd <= exp_rd();
      m_data <= (exp_rd() && exp_inr()) ? shadow[m_off] : 32'd0;
      m_hdr  <= cpl_hdr(exp_rd(), exp_ur(), m_bdf, m_rid, m_tag);
    end else if (tx_ready) begin
      m_busy <= 1'b0;
      m_age  <= 0;
      if (exp_ur() && m_urcnt < 65535) m_urcnt <= m_urcnt + 1;
    end
  end

  // ---- per-cycle compare ----
  always @(negedge clk) begin
    chk("rx_ready", rx_ready, !m_busy);
    chk("cfg_rd_en", cfg_rd_en, m_busy && m_age == 1 && exp_rd() && exp_inr());
    chk("cfg_wr_en", cfg_wr_en, m_busy && m_age == 1 && exp_wr() && exp_inr() && m_be != 4'd0);
    if (m_busy && m_age == 1 && exp_inr() && (exp_rd() || (exp_wr() && m_be != 4'd0))) begin
      chk("cfg_addr_dw", cfg_addr_dw, m_off);
      chk("cfg_be", cfg_be, m_be);
      if (exp_wr()) chk("cfg_wdata", cfg_wdata, m_wd);
    end
    chk("tx_valid", tx_valid, m_busy && m_age == 2);
    if (m_busy && m_age == 2) begin
      chk("tx_hdr", tx_hdr, m_hdr);
      chk("tx_data", tx_data, m_data);
      chk("tx_has_data", tx_has_data, m_hasd);
    end
    if (rst) begin
      chk("rst_tx_hdr", tx_hdr, 96'd0);
      chk("rst_tx_data", tx_data, 32'd0);
      chk("rst_tx_has_data", tx_has_data, 1'b0);
      chk("rst_cfg_addr", cfg_addr_dw, 10'd0);
      chk("rst_cfg_wdata", cfg_wdata, 32'd0);
      chk("rst_cfg_be", cfg_be, 4'd0);
    end
`ifdef CFG_UR_CNT_EN
    chk("ur_count", ur_count, m_urcnt[15:0]);
`endif
  end

  // ---- stimulus ----
  bit rnd_txr = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_txr) tx_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [95:0] h, input logic [31:0] d);
    int last;
    last = acc_cnt;
    rx_hdr = h; rx_data = d; rx_valid = 1'b1;
    for (int i = 0; i < 200 && acc_cnt == last; i++) step();
    if (acc_cnt == last) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
    end
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0]  ft;
    logic [9:0]  len, off;
    logic [31:0] w;
    int          last;

    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      mem[i] = w; shadow[i] = w;
    end
    mem[0] = 32'hABCD1234; shadow[0] = 32'hABCD1234;
    mem[4] = 32'h11223344; shadow[4] = 32'h11223344;

    rx_valid = 1'b0; rx_hdr = '0; rx_data = '0; tx_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_rx_ready", rx_ready, 1'b1);
    chk("reset_tx_valid", tx_valid, 1'b0);
    chk("reset_rd_en", cfg_rd_en, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    step();

    // 1: CfgRd0 off 0, tag 5
    send(mk_req(8'h04, 10'd1, 16'h1234, 8'h05, 4'hF, 16'h0100, 10'd0), 32'd0);
    @(negedge clk);
    chk("t1_rd_strobe", cfg_rd_en, 1'b1);
    chk("t1_addr", cfg_addr_dw, 10'd0);
    step(); @(negedge clk);
    chk("t1_tx_valid", tx_valid, 1'b1);
    chk("t1_data", tx_data, 32'hABCD1234);
    chk("t1_fmt", tx_hdr[31:24], 8'h4A);
    chk("t1_status", tx_hdr[47:45], 3'b000);
    chk("t1_bytecnt", tx_hdr[43:32], 12'd4);
    chk("t1_tag", tx_hdr[79:72], 8'h05);
    step();

    // 2: CfgWr0 off 4, BE 0011
    send(mk_req(8'h44, 10'd1, 16'h2222, 8'h09, 4'b0011, 16'h0100, 10'd4), 32'h0000BEEF);
    @(negedge clk);
    chk("t2_wr_strobe", cfg_wr_en, 1'b1);
    chk("t2_be", cfg_be, 4'b0011);
    chk("t2_rd_strobe", cfg_rd_en, 1'b0);
    step(); @(negedge clk);
    chk("t2_has_data", tx_has_data, 1'b0);
    chk("t2_len", tx_hdr[9:0], 10'd0);
    chk("t2_fmt", tx_hdr[31:24], 8'h0A);
    step();
    chk("t2_mem", mem[4], 32'h1122BEEF);

    // 3: CfgRd1 -> UR
    send(mk_req(8'h05, 10'd1, 16'h3333, 8'h0C, 4'hF, 16'h0200, 10'd2), 32'd0);
    @(negedge clk);
    chk("t3_no_rd", cfg_rd_en, 1'b0);
    chk("t3_no_wr", cfg_wr_en, 1'b0);
    step(); @(negedge clk);
    chk("t3_status", tx_hdr[47:45], 3'b001);
    chk("t3_has_data", tx_has_data, 1'b0);
    step();
`ifdef CFG_UR_CNT_EN
    @(negedge clk);
    chk("t3_ur_count", ur_count, 16'd1);
`endif

    // 4: CfgRd0 off 70 (unimplemented)
    send(mk_req(8'h04, 10'd1, 16'h4444, 8'h11, 4'hF, 16'h0100, 10'd70), 32'd0);
    @(negedge clk);
    chk("t4_no_rd", cfg_rd_en, 1'b0);
    step(); @(negedge clk);
    chk("t4_data", tx_data, 32'd0);
    chk("t4_has_data", tx_has_data, 1'b1);
    chk("t4_status", tx_hdr[47:45], 3'b000);
    step();

    // 5: tx backpressure for 10 cycles with a second request waiting
    tx_ready = 1'b0;
    send(mk_req(8'h04, 10'd1, 16'h5555, 8'h07, 4'hF, 16'h0100, 10'd1), 32'd0);
    rx_hdr = mk_req(8'h44, 10'd1, 16'h5556, 8'h08, 4'hF, 16'h0100, 10'd3);
    rx_data = 32'h5A5A5A5A; rx_valid = 1'b1;
    last = acc_cnt;
    step();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_tx_valid", tx_valid, 1'b1);
      chk("t5_tag", tx_hdr[79:72], 8'h07);
      chk("t5_data", tx_data, shadow[1]);
      chk("t5_rx_ready", rx_ready, 1'b0);
      step();
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 20 && acc_cnt == last; i++) step();
    chk("t5_second_accepted", acc_cnt - last, 1);
    rx_valid = 1'b0;
    step(); step();

    // 6: reset in ACCESS aborts the request
    send(mk_req(8'h04, 10'd1, 16'h6666, 8'h0E, 4'hF, 16'h0100, 10'd5), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rd_en", cfg_rd_en, 1'b0);
    chk("t6_tx_valid", tx_valid, 1'b0);
    chk("t6_rx_ready", rx_ready, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_cpl", tx_valid, 1'b0);
      step();
    end

    // randomized traffic
    rnd_txr = 1'b1;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: ft = 8'h04;
        4, 5, 6, 7: ft = 8'h44;
        8:          ft = ($urandom_range(0, 1) != 0) ? 8'h05 : 8'h45;
        default:    ft = 8'($urandom);
      endcase
      len = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'd1;
      off = ($urandom_range(0, 4) == 0) ? 10'($urandom_range(64, 1023)) : 10'($urandom_range(0, 63));
      send(mk_req(ft, len, 16'($urandom), 8'($urandom), 4'($urandom), 16'($urandom), off), $urandom);
      repeat ($urandom_range(0, 2)) step();
    end
    rnd_txr = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 50 && m_busy; i++) step();
    chk("drain_idle", m_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
